// File: rtl/fcb_rfu_be_fifo_if.sv
// Bundle of the FCB RFU byte-enable FIFO request and status signals.
// The master modport is the register-interface side, the slave modport is the FIFO.
interface fcb_rfu_be_fifo_if #(
  parameter int DEPTH_BITS = 2,
  parameter int BYTE_LANES = 4
);
  localparam int DW = 8 * BYTE_LANES;

  logic                  fifo_flush;
  logic                  fifo_wr_en;
  logic [BYTE_LANES-1:0] fifo_wr_be;
  logic [DW-1:0]         fifo_wr_data;
  logic                  fifo_rd_en;
  logic                  fifo_err_clr;

  logic [DW-1:0]         fifo_rd_data;
  logic [DEPTH_BITS:0]   fifo_level;
  logic                  fifo_empty_flag;
  logic                  fifo_empty_p1_flag;
  logic                  fifo_full_flag;
  logic                  fifo_full_m1_flag;
  logic                  fifo_almost_full;
  logic                  fifo_almost_empty;
  logic                  fifo_overflow;
  logic                  fifo_underflow;

  modport master (
    output fifo_flush, fifo_wr_en, fifo_wr_be, fifo_wr_data, fifo_rd_en, fifo_err_clr,
    input  fifo_rd_data, fifo_level, fifo_empty_flag, fifo_empty_p1_flag,
           fifo_full_flag, fifo_full_m1_flag, fifo_almost_full, fifo_almost_empty,
           fifo_overflow, fifo_underflow
  );

  modport slave (
    input  fifo_flush, fifo_wr_en, fifo_wr_be, fifo_wr_data, fifo_rd_en, fifo_err_clr,
    output fifo_rd_data, fifo_level, fifo_empty_flag, fifo_empty_p1_flag,
           fifo_full_flag, fifo_full_m1_flag, fifo_almost_full, fifo_almost_empty,
           fifo_overflow, fifo_underflow
  );
endinterface

// File: rtl/fcb_rfu_be_fifo.sv
// Register-file FIFO with per-byte write enables, guarded push/pop, sticky
// overflow/underflow, synchronous flush, level output and threshold flags.
// Read side is fall-through: the head slot is always visible on rd_data.
module fcb_rfu_be_fifo #(
  parameter int DEPTH_BITS   = 2,
  parameter int BYTE_LANES   = 4,
  parameter int BE_ZERO_FILL = 0,
  parameter int AFULL_LVL    = (1 << DEPTH_BITS) - 1,
  parameter int AEMPTY_LVL   = 1
) (
  input  logic              fifo_clk,
  input  logic              fifo_rst_n,
  fcb_rfu_be_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int DW    = 8 * BYTE_LANES;
  localparam int LVL_W = DEPTH_BITS + 1;

  localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_DM1   = LVL_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_AF    = LVL_W'(AFULL_LVL);
  localparam logic [LVL_W-1:0] LVL_AE    = LVL_W'(AEMPTY_LVL);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic [DW-1:0]         mem_q [DEPTH];
  logic [DW-1:0]         wr_word_d;
  logic                  mem_we;

  logic                  empty;
  logic                  full;
  logic                  pop_acc;
  logic                  push_acc;

  // Full/empty come from the level counter only, never from pointer compare.
  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_DEPTH);

  // Qualify requests; a pop frees a slot so a push alongside it is legal when full.
  always_comb begin
    pop_acc  = bus.fifo_rd_en & ~empty;
    push_acc = bus.fifo_wr_en & (~full | pop_acc);
    mem_we   = push_acc & ~bus.fifo_flush;
  end

  // Next-state for pointers, level and sticky errors; flush overrides requests.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q & ~bus.fifo_err_clr;
    underflow_d = underflow_q & ~bus.fifo_err_clr;
    if (bus.fifo_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_acc & ~pop_acc) level_d = level_q + LVL_ONE;
      if (pop_acc & ~push_acc) level_d = level_q - LVL_ONE;
      // Set has priority over a same-cycle err_clr.
      if (bus.fifo_wr_en & ~push_acc) overflow_d  = 1'b1;
      if (bus.fifo_rd_en & ~pop_acc)  underflow_d = 1'b1;
    end
  end

  // Merge the pushed lanes with zero-fill or the slot's stale bytes.
  always_comb begin
    wr_word_d = '0;
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (bus.fifo_wr_be[i])
        wr_word_d[8*i +: 8] = bus.fifo_wr_data[8*i +: 8];
      else if (BE_ZERO_FILL != 0)
        wr_word_d[8*i +: 8] = 8'h00;
      else
        wr_word_d[8*i +: 8] = mem_q[wr_ptr_q][8*i +: 8];
    end
  end

  // Control state: asynchronous active-low reset.
  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge fifo_clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_word_d;
  end

  assign bus.fifo_rd_data       = mem_q[rd_ptr_q];
  assign bus.fifo_level         = level_q;
  assign bus.fifo_empty_flag    = empty;
  assign bus.fifo_empty_p1_flag = (level_q == LVL_ONE);
  assign bus.fifo_full_flag     = full;
  assign bus.fifo_full_m1_flag  = (level_q == LVL_DM1);
  assign bus.fifo_almost_full   = (level_q >= LVL_AF);
  assign bus.fifo_almost_empty  = (level_q <= LVL_AE);
  assign bus.fifo_overflow      = overflow_q;
  assign bus.fifo_underflow     = underflow_q;
endmodule

// File: tb/tb_fcb_rfu_be_fifo.sv
// Bench for fcb_rfu_be_fifo: two instances (stale-lane and zero-fill) share one
// stimulus stream and are compared every cycle against a queue-based model,
// plus directed scenarios with hand-computed literal expectations.
module tb_fcb_rfu_be_fifo;
  localparam int DB = 2;
  localparam int BL = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        flush, we, re, ec;
  logic [3:0]  be;
  logic [31:0] wd;

  fcb_rfu_be_fifo_if #(.DEPTH_BITS(DB), .BYTE_LANES(BL)) bus0 ();
  fcb_rfu_be_fifo_if #(.DEPTH_BITS(DB), .BYTE_LANES(BL)) bus1 ();

  assign bus0.fifo_flush = flush;  assign bus1.fifo_flush = flush;
  assign bus0.fifo_wr_en = we;     assign bus1.fifo_wr_en = we;
  assign bus0.fifo_wr_be = be;     assign bus1.fifo_wr_be = be;
  assign bus0.fifo_wr_data = wd;   assign bus1.fifo_wr_data = wd;
  assign bus0.fifo_rd_en = re;     assign bus1.fifo_rd_en = re;
  assign bus0.fifo_err_clr = ec;   assign bus1.fifo_err_clr = ec;

  fcb_rfu_be_fifo #(.DEPTH_BITS(DB), .BYTE_LANES(BL), .BE_ZERO_FILL(0),
                    .AFULL_LVL(3), .AEMPTY_LVL(1))
    u0 (.fifo_clk(clk), .fifo_rst_n(rst_n), .bus(bus0));
  fcb_rfu_be_fifo #(.DEPTH_BITS(DB), .BYTE_LANES(BL), .BE_ZERO_FILL(1),
                    .AFULL_LVL(3), .AEMPTY_LVL(1))
    u1 (.fifo_clk(clk), .fifo_rst_n(rst_n), .bus(bus1));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] d0;   // stale-lane instance word
    logic [3:0]  k0;   // which bytes of d0 are known
    logic [31:0] d1;   // zero-fill instance word
  } ent_t;

  ent_t        mq[$];
  logic [31:0] slot0[DEPTH];
  logic [3:0]  slotk[DEPTH];
  int          m_wp;
  bit          m_ovf, m_udf;

  function automatic logic [31:0] bm(input logic [3:0] k);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{k[i]}};
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wp = 0;
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic model_update();
    int sz;
    bit pop, push, so, su;
    ent_t e;
    if (flush) begin
      mq.delete();
      m_wp = 0;
      m_ovf = m_ovf & ~ec;
      m_udf = m_udf & ~ec;
      return;
    end
    sz   = mq.size();
    pop  = re && sz > 0;
    push = we && (sz < DEPTH || pop);
    so   = we && !push;
    su   = re && !pop;
    if (pop) void'(mq.pop_front());
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          e.d0[8*i +: 8] = wd[8*i +: 8];
          e.k0[i]        = 1'b1;
          e.d1[8*i +: 8] = wd[8*i +: 8];
        end else begin
          e.d0[8*i +: 8] = slot0[m_wp][8*i +: 8];
          e.k0[i]        = slotk[m_wp][i];
          e.d1[8*i +: 8] = 8'h00;
        end
      end
      slot0[m_wp] = e.d0;
      slotk[m_wp] = e.k0;
      mq.push_back(e);
      m_wp = (m_wp + 1) % DEPTH;
    end
    m_ovf = so | (m_ovf & ~ec);
    m_udf = su | (m_udf & ~ec);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      int sz;
      sz = mq.size();
      chk("level0", 64'(bus0.fifo_level), 64'(sz));
      chk("level1", 64'(bus1.fifo_level), 64'(sz));
      chk("empty", 64'({bus0.fifo_empty_flag, bus1.fifo_empty_flag}), {62'd0, {2{sz == 0}}});
      chk("empty_p1", 64'({bus0.fifo_empty_p1_flag, bus1.fifo_empty_p1_flag}), {62'd0, {2{sz == 1}}});
      chk("full", 64'({bus0.fifo_full_flag, bus1.fifo_full_flag}), {62'd0, {2{sz == DEPTH}}});
      chk("full_m1", 64'({bus0.fifo_full_m1_flag, bus1.fifo_full_m1_flag}), {62'd0, {2{sz == DEPTH-1}}});
      chk("almost_full", 64'({bus0.fifo_almost_full, bus1.fifo_almost_full}), {62'd0, {2{sz >= 3}}});
      chk("almost_empty", 64'({bus0.fifo_almost_empty, bus1.fifo_almost_empty}), {62'd0, {2{sz <= 1}}});
      chk("overflow", 64'({bus0.fifo_overflow, bus1.fifo_overflow}), {62'd0, {2{m_ovf}}});
      chk("underflow", 64'({bus0.fifo_underflow, bus1.fifo_underflow}), {62'd0, {2{m_udf}}});
      if (sz > 0) begin
        chk("rd_data0", 64'(bus0.fifo_rd_data & bm(mq[0].k0)), 64'(mq[0].d0 & bm(mq[0].k0)));
        chk("rd_data1", 64'(bus1.fifo_rd_data), 64'(mq[0].d1));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    #2;
  endtask

  task automatic drive(input logic fl, input logic w, input logic [3:0] b,
                       input logic [31:0] d, input logic r, input logic c);
    flush = fl; we = w; be = b; wd = d; re = r; ec = c;
    tick();
    flush = 0; we = 0; re = 0; ec = 0;
  endtask

  initial begin
    flush = 0; we = 0; re = 0; ec = 0; be = 4'h0; wd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot0[i] = '0;
      slotk[i] = 4'h0;
    end
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_level", 64'(bus0.fifo_level), 64'd0);
    chk("rst_empty", 64'(bus0.fifo_empty_flag), 64'd1);
    chk("rst_aempty", 64'(bus0.fifo_almost_empty), 64'd1);
    chk("rst_full", 64'(bus0.fifo_full_flag), 64'd0);
    chk("rst_ovf", 64'(bus0.fifo_overflow), 64'd0);
    chk("rst_afull", 64'(bus0.fifo_almost_full), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // first word latency
    drive(0, 1, 4'hF, 32'hA5A5_0001, 0, 0);
    chk("fw_data", 64'(bus0.fifo_rd_data), 64'hA5A5_0001);
    chk("fw_level", 64'(bus0.fifo_level), 64'd1);
    chk("fw_ep1", 64'(bus0.fifo_empty_p1_flag), 64'd1);
    drive(0, 0, 4'h0, 0, 1, 0);

    // fill, overflow, drain
    for (int i = 1; i <= 4; i++) drive(0, 1, 4'hF, 32'(i), 0, 0);
    drive(0, 1, 4'hF, 32'd5, 0, 0);
    chk("ovf_full", 64'(bus0.fifo_full_flag), 64'd1);
    chk("ovf_level", 64'(bus0.fifo_level), 64'd4);
    chk("ovf_flag0", 64'(bus0.fifo_overflow), 64'd1);
    chk("ovf_flag1", 64'(bus1.fifo_overflow), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 64'(bus0.fifo_rd_data), 64'(i));
      drive(0, 0, 4'h0, 0, 1, 0);
    end
    chk("drain_empty", 64'(bus0.fifo_empty_flag), 64'd1);
    drive(0, 0, 4'h0, 0, 0, 1);
    chk("ovf_clr", 64'(bus0.fifo_overflow), 64'd0);

    // full with simultaneous push+pop across several wraps
    for (int i = 1; i <= 4; i++) drive(0, 1, 4'hF, 32'(i), 0, 0);
    for (int k = 0; k < 12; k++) begin
      drive(0, 1, 4'hF, 32'(5 + k), 1, 0);
      chk("fullrw_level", 64'(bus0.fifo_level), 64'd4);
      chk("fullrw_data", 64'(bus1.fifo_rd_data), 64'(k + 2));
    end
    chk("fullrw_ovf", 64'(bus0.fifo_overflow), 64'd0);
    drive(1, 0, 4'h0, 0, 0, 0);

    // empty with push+pop, then underflow clear rules
    drive(0, 1, 4'hF, 32'd7, 1, 0);
    chk("udf_level", 64'(bus0.fifo_level), 64'd1);
    chk("udf_set", 64'(bus0.fifo_underflow), 64'd1);
    chk("udf_data", 64'(bus0.fifo_rd_data), 64'd7);
    drive(0, 0, 4'h0, 0, 0, 1);
    chk("udf_clr", 64'(bus0.fifo_underflow), 64'd0);
    drive(0, 0, 4'h0, 0, 1, 0);
    drive(0, 0, 4'h0, 0, 1, 1);
    chk("udf_setwins", 64'(bus0.fifo_underflow), 64'd1);
    drive(0, 0, 4'h0, 0, 0, 1);

    // stale vs zero-filled lanes
    drive(1, 0, 4'h0, 0, 0, 0);
    drive(0, 1, 4'hF, 32'h1122_3344, 0, 0);
    drive(0, 0, 4'h0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 4'hF, $urandom, 0, 0);
      drive(0, 0, 4'h0, 0, 1, 0);
    end
    drive(0, 1, 4'b0101, 32'hFFFF_FFFF, 0, 0);
    chk("be_stale", 64'(bus0.fifo_rd_data), 64'h11FF_33FF);
    chk("be_zero", 64'(bus1.fifo_rd_data), 64'h00FF_00FF);
    drive(0, 0, 4'h0, 0, 1, 0);

    // thresholds, then flush with requests
    drive(0, 1, 4'hF, 32'hA, 0, 0);
    chk("thr1_ae", 64'(bus0.fifo_almost_empty), 64'd1);
    drive(0, 1, 4'hF, 32'hB, 0, 0);
    chk("thr2_ae", 64'(bus0.fifo_almost_empty), 64'd0);
    chk("thr2_af", 64'(bus0.fifo_almost_full), 64'd0);
    drive(0, 1, 4'hF, 32'hC, 0, 0);
    chk("thr3_af", 64'(bus0.fifo_almost_full), 64'd1);
    drive(1, 1, 4'hF, 32'hD, 1, 0);
    chk("flush_level", 64'(bus0.fifo_level), 64'd0);
    chk("flush_empty", 64'(bus0.fifo_empty_flag), 64'd1);
    chk("flush_err", 64'({bus0.fifo_overflow, bus0.fifo_underflow}), 64'd0);

    // randomized traffic with an async reset in the middle
    for (int n = 0; n < 1200; n++) begin
      logic fl, c;
      fl = ($urandom_range(0, 99) < 3);
      c  = fl ? 1'b0 : ($urandom_range(0, 99) < 10);
      drive(fl, $urandom_range(0, 99) < 60, 4'($urandom), $urandom,
            $urandom_range(0, 99) < 50, c);
      if (n == 600) begin
        for (int i = 0; i < 3; i++) drive(0, 1, 4'hF, $urandom, 0, 0);
        drive(0, 1, 4'hF, 32'h0, 1, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_level", 64'(bus0.fifo_level), 64'd0);
        chk("arst_empty", 64'(bus1.fifo_empty_flag), 64'd1);
        chk("arst_err", 64'({bus0.fifo_overflow, bus0.fifo_underflow}), 64'd0);
        tick();
        rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
